// File: rtl/res_pkg.sv
// Shared constants and state encoding for the result-matrix serializer.
package res_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int MAX_DIM     = 4;
  localparam int MATRIX_SIZE = MAX_DIM * MAX_DIM;
  localparam int DIM_W       = 3;
  localparam int IDX_W       = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Keeps the row/col counters at least one bit wide even for MAX_DIM of 1.
  function automatic int cntWidth(input int maxDim);
    return (maxDim > 1) ? $clog2(maxDim) : 1;
  endfunction

endpackage

// File: rtl/res_serializer_if.sv
// Valid/ready element stream leaving the serializer, with index and last flag.
interface res_serializer_if #(
  parameter int DATA_WIDTH = res_pkg::DATA_WIDTH
);
  import res_pkg::*;

  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [IDX_W-1:0]      idx_o;
  logic                  last_o;

  modport master (output valid_o, data_o, idx_o, last_o, input ready_i);
  modport slave  (input valid_o, data_o, idx_o, last_o, output ready_i);

endinterface

// File: rtl/res_idx_counter.sv
// Row/column walker over a dim x dim window; wraps col at dim-1 and flags the final element.
module res_idx_counter #(
  parameter int CNT_W = 2,
  parameter int DIM_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [DIM_W-1:0] i_dim,
  output logic [CNT_W-1:0] o_row,
  output logic [CNT_W-1:0] o_col,
  output logic             o_last
);

  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [DIM_W-1:0] w_dimM1;
  logic             w_rowEnd;
  logic             w_colEnd;

  assign w_dimM1  = i_dim - DIM_W'(1);
  assign w_rowEnd = (DIM_W'(r_row) == w_dimM1);
  assign w_colEnd = (DIM_W'(r_col) == w_dimM1);
  assign o_last   = w_rowEnd & w_colEnd;
  assign o_row    = r_row;
  assign o_col    = r_col;

  // Finishing the window returns to (0,0) so an idle block always points at element 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (o_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_colEnd) begin
        r_col <= '0;
        r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/res_serializer.sv
// Captures a full result matrix in one cycle and streams its dim x dim corner row-major.
module res_serializer #(
  parameter int DATA_WIDTH  = res_pkg::DATA_WIDTH,
  parameter int MAX_DIM     = res_pkg::MAX_DIM,
  parameter int MATRIX_SIZE = res_pkg::MATRIX_SIZE
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              done_i,
  input  logic [2:0]                        dim_i,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] res_flat_i,
  res_serializer_if.master                  m_out,
  output logic                              busy_o,
  output logic                              overrun_o,
  output logic                              dim_err_o
);
  import res_pkg::*;

  localparam int               CNT_W     = cntWidth(MAX_DIM);
  localparam logic [DIM_W-1:0] MAX_DIM_D = DIM_W'(MAX_DIM);
  localparam logic [IDX_W-1:0] MAX_DIM_I = IDX_W'(MAX_DIM);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf [MATRIX_SIZE];
  logic [DIM_W-1:0]      r_dim;
  logic                  r_overrun;
  logic                  r_dimErr;

  logic [CNT_W-1:0]      w_row;
  logic [CNT_W-1:0]      w_col;
  logic                  w_cntLast;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_stream;
  logic                  w_xfer;
  logic                  w_lastXfer;
  logic                  w_dimLegal;
  logic                  w_capture;

  assign w_stream   = (r_state == STREAM);
  assign w_xfer     = w_stream & m_out.ready_i;
  assign w_lastXfer = w_xfer & w_cntLast;
  assign w_dimLegal = (dim_i != '0) && (dim_i <= MAX_DIM_D);
  // A new matrix is taken when idle, or exactly on the final handshake so streams chain without a bubble.
  assign w_capture  = done_i & w_dimLegal & (~w_stream | w_lastXfer);
  assign w_idx      = IDX_W'(w_row) * MAX_DIM_I + IDX_W'(w_col);

  res_idx_counter #(
    .CNT_W (CNT_W),
    .DIM_W (DIM_W)
  ) u_idx_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clear   (w_capture),
    .i_advance (w_xfer),
    .i_dim     (r_dim),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_cntLast)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else if (w_capture) begin
      r_state <= STREAM;
    end else if (w_lastXfer) begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        r_buf[k] <= '0;
      end
      r_dim <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < MATRIX_SIZE; k++) begin
        r_buf[k] <= res_flat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      r_dim <= dim_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
      r_dimErr  <= 1'b0;
    end else begin
      if (done_i & w_dimLegal & w_stream & ~w_lastXfer) begin
        r_overrun <= 1'b1;
      end
      if (done_i & ~w_dimLegal) begin
        r_dimErr <= 1'b1;
      end
    end
  end

  assign m_out.valid_o = w_stream;
  assign m_out.last_o  = w_stream & w_cntLast;
  assign m_out.idx_o   = w_stream ? w_idx : '0;
  assign m_out.data_o  = w_stream ? r_buf[w_idx] : '0;
  assign busy_o        = w_stream;
  assign overrun_o     = r_overrun;
  assign dim_err_o     = r_dimErr;

endmodule

// File: tb/tb_res_serializer.sv
// Directed bench for res_serializer: one task per scenario with hand-computed expectations.
module tb_res_serializer;

  localparam int DW = 32;
  localparam int MS = 16;

  logic             clk;
  logic             rst;
  logic             done;
  logic [2:0]       dim;
  logic [MS*DW-1:0] flat;
  logic             busy;
  logic             overrun;
  logic             dimErr;

  int checks;
  int failures;

  res_serializer_if #(.DATA_WIDTH(DW)) sIf ();

  res_serializer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .done_i     (done),
    .dim_i      (dim),
    .res_flat_i (flat),
    .m_out      (sIf),
    .busy_o     (busy),
    .overrun_o  (overrun),
    .dim_err_o  (dimErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic d, input logic [2:0] dm, input logic r);
    done        = d;
    dim         = dm;
    sIf.ready_i = r;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    flat = '0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({sIf.valid_o, sIf.last_o, busy, overrun, dimErr} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {sIf.valid_o, sIf.last_o, busy, overrun, dimErr});
    end
    checks++;
    if (sIf.data_o !== 32'h0 || sIf.idx_o !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_data_idx: got %0h/%0h expected 0/0", sIf.data_o, sIf.idx_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sIf.valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_valid: got %b expected 0", sIf.valid_o);
    end
  endtask

  task automatic test_dim4_full();
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(k + 1);
    applyStimulus(1'b1, 3'd4, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b1);
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'(n + 1)) begin
        failures++;
        $display("[TB] FAIL dim4_data[%0d]: got v=%b d=%0h expected v=1 d=%0h", n, sIf.valid_o, sIf.data_o, n + 1);
      end
      checks++;
      if (sIf.last_o !== (n == 15)) begin
        failures++;
        $display("[TB] FAIL dim4_last[%0d]: got %b expected %b", n, sIf.last_o, (n == 15));
      end
      @(negedge clk);
    end
    checks++;
    if (sIf.valid_o !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dim4_end_idle: got v=%b busy=%b expected 0/0", sIf.valid_o, busy);
    end
  endtask

  task automatic test_dim2_window();
    int expIdx [4] = '{0, 1, 4, 5};
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(k);
    applyStimulus(1'b1, 3'd2, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'(expIdx[n]) || sIf.idx_o !== 4'(expIdx[n])) begin
        failures++;
        $display("[TB] FAIL dim2_elem[%0d]: got v=%b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                 n, sIf.valid_o, sIf.data_o, sIf.idx_o, expIdx[n], expIdx[n]);
      end
      checks++;
      if (sIf.last_o !== (n == 3)) begin
        failures++;
        $display("[TB] FAIL dim2_last[%0d]: got %b expected %b", n, sIf.last_o, (n == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (sIf.valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dim2_end_idle: got %b expected 0", sIf.valid_o);
    end
  endtask

  task automatic test_ready_toggle();
    int expIdx [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int n = 0;
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(16 + k);
    applyStimulus(1'b1, 3'd3, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 40 && n < 9; c++) begin
      applyStimulus(1'b0, 3'd0, (c % 2) == 0);
      checks++;
      if (sIf.valid_o !== 1'b1 || sIf.idx_o !== 4'(expIdx[n]) || sIf.data_o !== 32'(16 + expIdx[n])) begin
        failures++;
        $display("[TB] FAIL toggle_elem[c%0d]: got v=%b i=%0d d=%0h expected v=1 i=%0d d=%0h",
                 c, sIf.valid_o, sIf.idx_o, sIf.data_o, expIdx[n], 16 + expIdx[n]);
      end
      checks++;
      if (sIf.last_o !== (n == 8)) begin
        failures++;
        $display("[TB] FAIL toggle_last[c%0d]: got %b expected %b", c, sIf.last_o, (n == 8));
      end
      if (sIf.ready_i) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 9 || sIf.valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL toggle_count: got transfers=%0d v=%b expected 9/0", n, sIf.valid_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(256 + k);
    applyStimulus(1'b1, 3'd4, 1'b1);
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      if (n == 2) begin
        flat = '1;
        applyStimulus(1'b1, 3'd2, 1'b1);
      end else if (n == 15) begin
        flat = '0;
        flat[DW-1:0] = 32'hAB;
        applyStimulus(1'b1, 3'd1, 1'b1);
      end else begin
        applyStimulus(1'b0, 3'd0, 1'b1);
      end
      checks++;
      if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'(256 + n)) begin
        failures++;
        $display("[TB] FAIL overrun_stream[%0d]: got v=%b d=%0h expected v=1 d=%0h", n, sIf.valid_o, sIf.data_o, 256 + n);
      end
      if (n == 0 || n == 5) begin
        checks++;
        if (overrun !== (n == 5)) begin
          failures++;
          $display("[TB] FAIL overrun_flag[%0d]: got %b expected %b", n, overrun, (n == 5));
        end
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, 3'd0, 1'b1);
    checks++;
    if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'hAB || sIf.last_o !== 1'b1 || sIf.idx_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL chained_elem: got v=%b d=%0h l=%b i=%0d expected v=1 d=ab l=1 i=0",
               sIf.valid_o, sIf.data_o, sIf.last_o, sIf.idx_o);
    end
    @(negedge clk);
    checks++;
    if (sIf.valid_o !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL chained_end: got v=%b ovr=%b expected 0/1", sIf.valid_o, overrun);
    end
  endtask

  task automatic test_dim_err();
    logic [2:0] badDims [2] = '{3'd0, 3'd5};
    for (int b = 0; b < 2; b++) begin
      pulseReset();
      checks++;
      if (dimErr !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("[TB] FAIL dimerr_pre[%0d]: got err=%b ovr=%b expected 0/0", b, dimErr, overrun);
      end
      applyStimulus(1'b1, badDims[b], 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 1'b1);
      repeat (2) begin
        checks++;
        if (dimErr !== 1'b1 || sIf.valid_o !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL dimerr_dim%0d: got err=%b v=%b busy=%b expected 1/0/0", badDims[b], dimErr, sIf.valid_o, busy);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_midstream();
    pulseReset();
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(k + 1);
    applyStimulus(1'b1, 3'd4, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'd5) begin
      failures++;
      $display("[TB] FAIL midrst_pre: got v=%b d=%0h expected v=1 d=5", sIf.valid_o, sIf.data_o);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sIf.valid_o, sIf.last_o, busy, overrun, dimErr} !== 5'b0 || sIf.data_o !== 32'h0 || sIf.idx_o !== 4'h0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got flags=%b d=%0h i=%0d expected 0/0/0",
               {sIf.valid_o, sIf.last_o, busy, overrun, dimErr}, sIf.data_o, sIf.idx_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (sIf.valid_o !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midrst_quiet[%0d]: got v=%b busy=%b expected 0/0", c, sIf.valid_o, busy);
      end
    end
    for (int k = 0; k < MS; k++) flat[k*DW +: DW] = 32'(k + 7);
    applyStimulus(1'b1, 3'd2, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checks++;
    if (sIf.valid_o !== 1'b1 || sIf.data_o !== 32'd7 || sIf.idx_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL midrst_restart: got v=%b d=%0h i=%0d expected v=1 d=7 i=0", sIf.valid_o, sIf.data_o, sIf.idx_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    $display("[TB] starting res_serializer bench");
    test_reset();
    test_dim4_full();
    test_dim2_window();
    test_ready_toggle();
    test_back_to_back();
    test_dim_err();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/res_serializer.md
RES_SERIALIZER -- requirements
Module: res_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one result element.
REQ-002 Parameter MAX_DIM, default 4, maximum matrix dimension.
REQ-003 Parameter MATRIX_SIZE, default 16 (MAX_DIM**2), number of result elements.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 done_i  input  1  one-cycle pulse: the result matrix is valid on res_flat_i this cycle.
REQ-007 dim_i  input  3  active matrix dimension, 1..MAX_DIM, sampled with done_i.
REQ-008 res_flat_i  input  MATRIX_SIZE*DATA_WIDTH  results, element k at bits [k*DATA_WIDTH +: DATA_WIDTH], row-major k = row*MAX_DIM+col.
REQ-009 ready_i  input  1  downstream accepts data_o this cycle.
REQ-010 valid_o  output  1  data_o holds an element.
REQ-011 data_o  output  DATA_WIDTH  current element.
REQ-012 idx_o  output  4  buffer index k of the current element.
REQ-013 last_o  output  1  current element is the final one of the matrix.
REQ-014 busy_o  output  1  high in STREAM state.
REQ-015 overrun_o  output  1  sticky: a done_i was dropped.
REQ-016 dim_err_o  output  1  sticky: done_i arrived with dim_i of 0 or greater than MAX_DIM.

Function
REQ-017 The FSM SHALL have two states: IDLE and STREAM.
REQ-018 In IDLE, done_i with a legal dim_i SHALL capture all MATRIX_SIZE elements and dim_i into internal registers, and SHALL enter STREAM on the same edge.
REQ-019 The first element SHALL appear with valid_o=1 in the cycle after the done_i edge (latency 1).
REQ-020 In STREAM, the block SHALL emit only the dim x dim sub-matrix: rows 0..dim-1, cols 0..dim-1, row-major, for dim*dim elements in total.
REQ-021 A transfer SHALL occur on a rising edge where valid_o=1 and ready_i=1; the column SHALL advance, wrap to 0 at dim-1, and increment the row.
REQ-022 While valid_o=1 and ready_i=0, data_o, idx_o and last_o SHALL stay stable, and valid_o SHALL NOT drop.
REQ-023 last_o SHALL be high exactly when row=dim-1 and col=dim-1.
REQ-024 A transfer with last_o=1 SHALL return the FSM to IDLE and drive valid_o=0 next cycle, unless REQ-025 applies.
REQ-025 done_i with a legal dim_i coinciding with the last transfer SHALL recapture and remain in STREAM, with the new element 0 valid next cycle and no bubble.
REQ-026 done_i in STREAM at any other time SHALL be ignored, SHALL set overrun_o, and SHALL leave the current stream intact.
REQ-027 done_i with an illegal dim_i SHALL set dim_err_o, capture nothing, and cause no state change.
REQ-028 Row and col counters SHALL each be clog2(MAX_DIM) bits wide; idx_o = row*MAX_DIM+col, with no overflow for legal dim.
REQ-029 In IDLE, valid_o, last_o and busy_o SHALL be 0.

Reset
REQ-030 rst_i high SHALL immediately force IDLE and drive valid_o, data_o, idx_o, last_o, busy_o, overrun_o and dim_err_o to 0.
REQ-031 rst_i high SHALL clear the element buffer, the stored dim, and both counters to 0.
REQ-032 Reset asserted mid-stream SHALL abort the stream; after release no element is emitted until a new done_i arrives.

Structure
REQ-033 Package res_pkg SHALL hold DATA_WIDTH, MAX_DIM, MATRIX_SIZE and the state enum (IDLE, STREAM).
REQ-034 The design SHALL have one sub-module, res_idx_counter, a row/col counter with dim-bounded wrap and a last flag.
REQ-035 The element buffer SHALL be a flop array, not inferred RAM, so that the full matrix is captured in one cycle.

Verification
REQ-036 Scenario 1: dim=4, element k=k+1, ready_i=1 -> 16 transfers carrying 1..16; last_o only on data 16; valid_o low on the cycle after.
REQ-037 Scenario 2: dim=2, element k=k -> data 0,1,4,5 with idx 0,1,4,5; last_o on 5.
REQ-038 Scenario 3: dim=3, ready_i toggling 1,0,1,0 -> data and idx held during ready_i=0 cycles; 9 transfers total.
REQ-039 Scenario 4: done_i at 3rd transfer of a dim=4 stream -> overrun_o=1; stream completes unchanged. Then done_i (dim=1, value 0xAB) on the last transfer -> next cycle data_o=0xAB, last_o=1, no gap.
REQ-040 Scenario 5: done_i with dim_i=0, then with dim_i=5 -> dim_err_o=1; valid_o stays 0.
REQ-041 Scenario 6: rst_i pulsed asynchronously mid-stream (between edges) -> all outputs 0 immediately; no output activity until the next done_i.
